// File: rtl/sys_defs.sv
// Shared completion-stage definitions: FU completion packet, CDB source enum and helpers.
// N_CDB_SRC is the number of functional-unit sources feeding the CDB.
`ifndef N_CDB_SRC
`define N_CDB_SRC 6
`endif

package sys_defs;

    localparam int N_SRC = `N_CDB_SRC;
    localparam int SRC_W = 3;
    localparam int PR_W  = 6;
    localparam int ROB_W = 5;
    localparam int XLEN  = 32;

    typedef enum logic [SRC_W-1:0] {
        ALU_1  = 3'd0,
        ALU_2  = 3'd1,
        ALU_3  = 3'd2,
        MULT_1 = 3'd3,
        MULT_2 = 3'd4,
        BRANCH = 3'd5
    } CDB_SRC;

    typedef struct packed {
        logic [ROB_W-1:0] rob_idx;
        logic [PR_W-1:0]  pr_idx;
        logic [XLEN-1:0]  dest_value;
        logic             take_branch;
    } FU_COMPLETE_PACKET;

    function automatic logic [SRC_W-1:0] popcount(input logic [N_SRC-1:0] v);
        logic [SRC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_SRC; i++) begin
            c = c + {{(SRC_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [SRC_W-1:0] onehot_to_idx(input logic [N_SRC-1:0] oh);
        logic [SRC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (oh[i]) idx = SRC_W'(i);
        end
        return idx;
    endfunction

    // Source-index addition modulo N_SRC (operands always < N_SRC).
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] a,
                                                  input logic [SRC_W-1:0] b);
        logic [SRC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (SRC_W+1)'(N_SRC)) s = s - (SRC_W+1)'(N_SRC);
        return s[SRC_W-1:0];
    endfunction

endpackage

// File: rtl/complete_cdb_arb_rr_arb.sv
// CDB source arbiter: round-robin when COMPLETE_CDB_RR_EN is defined,
// otherwise fixed priority with the highest source index winning.
module cdb_rr_arb
    import sys_defs::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             squash,
    input  logic             en,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] grant
);

    logic w_found;

`ifdef COMPLETE_CDB_RR_EN
    logic [SRC_W-1:0] r_rr_ptr;
    logic [SRC_W-1:0] w_cand;
    logic [SRC_W-1:0] w_win_idx;

    // First requester at or after r_rr_ptr, wrapping modulo N_SRC.
    always_comb begin
        grant     = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        w_win_idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_cand = wrap_add(r_rr_ptr, SRC_W'(k));
            if (en && !w_found && req[w_cand]) begin
                grant[w_cand] = 1'b1;
                w_found       = 1'b1;
                w_win_idx     = w_cand;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (squash) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= wrap_add(w_win_idx, SRC_W'(1));
        end
    end
`else
    logic w_unused_seq;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (en && !w_found && req[i]) begin
                grant[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    // Fixed priority keeps no state, so the sequential inputs are not needed.
    assign w_unused_seq = ^{clock, reset_n, squash};
`endif

endmodule

// File: rtl/complete_cdb_arb.sv
// Completion-stage arbiter: six FU holding slots drained one per cycle onto a registered CDB.
// Arbitration order selected by COMPLETE_CDB_RR_EN (round-robin) or fixed priority when undefined.
module complete_cdb_arb
    import sys_defs::*;
(
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [N_SRC-1:0]              src_valid,
    input  FU_COMPLETE_PACKET [N_SRC-1:0] src_packet,
    output logic [N_SRC-1:0]              src_ready,
    output logic                          cdb_valid,
    output FU_COMPLETE_PACKET             cdb_packet,
    output logic [SRC_W-1:0]              cdb_src,
    input  logic                          cdb_stall,
    input  logic                          squash,
    output logic [SRC_W-1:0]              pending_cnt
);

    logic [N_SRC-1:0]              r_slot_valid;
    FU_COMPLETE_PACKET [N_SRC-1:0] r_slot_pkt;
    logic                          r_cdb_valid;
    FU_COMPLETE_PACKET             r_cdb_packet;
    logic [SRC_W-1:0]              r_cdb_src;

    logic                          w_adv;
    logic [N_SRC-1:0]              w_grant;
    logic [N_SRC-1:0]              w_accept;
    logic [SRC_W-1:0]              w_win_idx;

    assign w_adv = !r_cdb_valid || !cdb_stall;

    cdb_rr_arb u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .squash  (squash),
        .en      (w_adv),
        .req     (r_slot_valid),
        .grant   (w_grant)
    );

    assign w_win_idx = onehot_to_idx(w_grant);

    // A granted slot frees at this edge, so it may take a new packet in the same cycle.
    assign src_ready = ~r_slot_valid | w_grant;
    assign w_accept  = src_valid & src_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_valid <= '0;
            r_slot_pkt   <= '0;
        end else if (squash) begin
            r_slot_valid <= '0;
        end else begin
            r_slot_valid <= (r_slot_valid & ~w_grant) | w_accept;
            for (int i = 0; i < N_SRC; i++) begin
                if (w_accept[i]) r_slot_pkt[i] <= src_packet[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_packet <= '0;
            r_cdb_src    <= '0;
        end else if (squash) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_packet <= '0;
        end else if (w_adv) begin
            if (|w_grant) begin
                r_cdb_valid  <= 1'b1;
                r_cdb_packet <= r_slot_pkt[w_win_idx];
                r_cdb_src    <= w_win_idx;
            end else begin
                r_cdb_valid  <= 1'b0;
                r_cdb_packet <= '0;
            end
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_packet  = r_cdb_packet;
    assign cdb_src     = r_cdb_src;
    assign pending_cnt = popcount(r_slot_valid);

    a_grant_onehot : assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(w_grant) && ((w_grant & ~r_slot_valid) == '0));

endmodule

// File: tb/tb_complete_cdb_arb.sv
// Self-checking bench for complete_cdb_arb: directed scenarios plus randomized traffic
// against a slot/CDB reference model and a loss/duplication scoreboard.
module tb_complete_cdb_arb;
    import sys_defs::*;

    localparam int PW = $bits(FU_COMPLETE_PACKET);

    logic                          clock;
    logic                          reset_n;
    logic [N_SRC-1:0]              src_valid;
    FU_COMPLETE_PACKET [N_SRC-1:0] src_packet;
    logic [N_SRC-1:0]              src_ready;
    logic                          cdb_valid;
    FU_COMPLETE_PACKET             cdb_packet;
    logic [SRC_W-1:0]              cdb_src;
    logic                          cdb_stall;
    logic                          squash;
    logic [SRC_W-1:0]              pending_cnt;

    int n_checks;
    int n_fail;

    // Reference model state
    bit                m_full[N_SRC];
    FU_COMPLETE_PACKET m_pkt[N_SRC];
    bit                m_cv;
    FU_COMPLETE_PACKET m_cp;
    int                m_cs;
`ifdef COMPLETE_CDB_RR_EN
    int                m_ptr;
`endif
    logic [PW-1:0]     exp_q[$];
    int unsigned       tag;

    complete_cdb_arb dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .src_valid   (src_valid),
        .src_packet  (src_packet),
        .src_ready   (src_ready),
        .cdb_valid   (cdb_valid),
        .cdb_packet  (cdb_packet),
        .cdb_src     (cdb_src),
        .cdb_stall   (cdb_stall),
        .squash      (squash),
        .pending_cnt (pending_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic FU_COMPLETE_PACKET mk(input int pr, input int val);
        FU_COMPLETE_PACKET p;
        p.rob_idx     = 5'(pr + 3);
        p.pr_idx      = 6'(pr);
        p.dest_value  = 32'(val);
        p.take_branch = 1'(val);
        return p;
    endfunction

    function automatic int m_winner();
        if (m_cv && cdb_stall) return -1;
`ifdef COMPLETE_CDB_RR_EN
        for (int k = 0; k < N_SRC; k++) begin
            if (m_full[(m_ptr + k) % N_SRC]) return (m_ptr + k) % N_SRC;
        end
`else
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (m_full[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [N_SRC-1:0] m_ready();
        logic [N_SRC-1:0] r;
        int w;
        w = m_winner();
        for (int i = 0; i < N_SRC; i++) r[i] = !m_full[i] || (w == i);
        return r;
    endfunction

    function automatic logic [SRC_W-1:0] m_pend();
        int c;
        c = 0;
        for (int i = 0; i < N_SRC; i++) c += int'(m_full[i]);
        return SRC_W'(c);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N_SRC; i++) begin
            m_full[i] = 1'b0;
            m_pkt[i]  = '0;
        end
        m_cv = 1'b0;
        m_cp = '0;
        m_cs = 0;
`ifdef COMPLETE_CDB_RR_EN
        m_ptr = 0;
`endif
        exp_q.delete();
    endtask

    // Advance one rising edge, updating the model from the inputs held across it.
    task automatic tick();
        int w;
        bit acc[N_SRC];
        w = m_winner();
        for (int i = 0; i < N_SRC; i++) acc[i] = src_valid[i] && (!m_full[i] || (w == i));
        @(posedge clock);
        if (squash) begin
            for (int i = 0; i < N_SRC; i++) m_full[i] = 1'b0;
            m_cv = 1'b0;
            m_cp = '0;
`ifdef COMPLETE_CDB_RR_EN
            m_ptr = 0;
`endif
            exp_q.delete();
        end else begin
            if (!m_cv || !cdb_stall) begin
                if (w >= 0) begin
                    m_cv = 1'b1;
                    m_cp = m_pkt[w];
                    m_cs = w;
                    m_full[w] = 1'b0;
`ifdef COMPLETE_CDB_RR_EN
                    m_ptr = (w + 1) % N_SRC;
`endif
                end else begin
                    m_cv = 1'b0;
                    m_cp = '0;
                end
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (acc[i]) begin
                    m_full[i] = 1'b1;
                    m_pkt[i]  = src_packet[i];
                    exp_q.push_back(src_packet[i]);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        src_valid  = '0;
        src_packet = '0;
        cdb_stall  = 1'b0;
        squash     = 1'b0;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if ({cdb_valid, cdb_packet, cdb_src, pending_cnt} !== {1'b0, {PW{1'b0}}, 3'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b pkt=%h src=%0d pend=%0d, expected all zero",
                     cdb_valid, cdb_packet, cdb_src, pending_cnt);
        end
        n_checks++;
        if (src_ready !== 6'h3f) begin
            n_fail++;
            $display("FAIL reset_src_ready: got %b expected 111111", src_ready);
        end
    endtask

    task automatic test_single();
        src_valid     = 6'b000001;
        src_packet[0] = mk(7, 'h11);
        #1;
        n_checks++;
        if (src_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 1", src_ready[0]);
        end
        tick();
        src_valid = '0;
        #1;
        n_checks++;
        if ({cdb_valid, pending_cnt} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL single_held: got v=%0b pend=%0d expected v=0 pend=1", cdb_valid, pending_cnt);
        end
        tick();
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_packet.pr_idx, cdb_packet.dest_value, pending_cnt} !==
            {1'b1, 3'd0, 6'd7, 32'h11, 3'd0}) begin
            n_fail++;
            $display("FAIL single_bcast: got v=%0b src=%0d pr=%0d val=%h pend=%0d expected v=1 src=0 pr=7 val=11 pend=0",
                     cdb_valid, cdb_src, cdb_packet.pr_idx, cdb_packet.dest_value, pending_cnt);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_one_cycle: got v=%0b expected 0", cdb_valid);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        squash = 1'b1;
        tick();
        squash = 1'b0;
        for (int i = 0; i < N_SRC; i++) src_packet[i] = mk(10 + i, 'h100 + i);
        src_valid = '1;
        #1;
        n_checks++;
        if (src_ready !== 6'h3f) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b expected 111111", src_ready);
        end
        tick();
        src_valid = '0;
        #1;
        n_checks++;
        if ({cdb_valid, pending_cnt} !== {1'b0, 3'd6}) begin
            n_fail++;
            $display("FAIL b2b_fill: got v=%0b pend=%0d expected v=0 pend=6", cdb_valid, pending_cnt);
        end
        for (int k = 0; k < N_SRC; k++) begin
`ifdef COMPLETE_CDB_RR_EN
            e = k;
`else
            e = N_SRC - 1 - k;
`endif
            tick();
            n_checks++;
            if ({cdb_valid, cdb_src, cdb_packet.pr_idx, pending_cnt} !==
                {1'b1, 3'(e), 6'(10 + e), 3'(N_SRC - 1 - k)}) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: got v=%0b src=%0d pr=%0d pend=%0d expected v=1 src=%0d pr=%0d pend=%0d",
                         k, cdb_valid, cdb_src, cdb_packet.pr_idx, pending_cnt, e, 10 + e, N_SRC - 1 - k);
            end
        end
        tick();
        n_checks++;
        if ({cdb_valid, pending_cnt} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL b2b_drained: got v=%0b pend=%0d expected 0 0", cdb_valid, pending_cnt);
        end
    endtask

    task automatic test_stall_refill();
        src_valid     = 6'b001000;
        src_packet[3] = mk(20, 'h200);
        #1;
        tick();
        src_packet[3] = mk(21, 'h201);
        #1;
        n_checks++;
        if (src_ready[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_ready: got %b expected 1", src_ready[3]);
        end
        tick();
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_packet.pr_idx, pending_cnt} !== {1'b1, 3'd3, 6'd20, 3'd1}) begin
            n_fail++;
            $display("FAIL refill_first: got v=%0b src=%0d pr=%0d pend=%0d expected 1 3 20 1",
                     cdb_valid, cdb_src, cdb_packet.pr_idx, pending_cnt);
        end
        cdb_stall     = 1'b1;
        src_packet[3] = mk(22, 'h202);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (src_ready !== 6'b110111) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got %b expected 110111", c, src_ready);
            end
            tick();
            n_checks++;
            if ({cdb_valid, cdb_src, cdb_packet, pending_cnt} !== {1'b1, 3'd3, mk(20, 'h200), 3'd1}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%0b src=%0d pkt=%h pend=%0d expected pr=20 held",
                         c, cdb_valid, cdb_src, cdb_packet, pending_cnt);
            end
        end
        cdb_stall = 1'b0;
        #1;
        n_checks++;
        if (src_ready[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL unstall_ready: got %b expected 1", src_ready[3]);
        end
        tick();
        src_valid = '0;
        n_checks++;
        if ({cdb_valid, cdb_packet.pr_idx, pending_cnt} !== {1'b1, 6'd21, 3'd1}) begin
            n_fail++;
            $display("FAIL refill_second: got v=%0b pr=%0d pend=%0d expected 1 21 1",
                     cdb_valid, cdb_packet.pr_idx, pending_cnt);
        end
        tick();
        n_checks++;
        if ({cdb_valid, cdb_packet.pr_idx, pending_cnt} !== {1'b1, 6'd22, 3'd0}) begin
            n_fail++;
            $display("FAIL refill_third: got v=%0b pr=%0d pend=%0d expected 1 22 0",
                     cdb_valid, cdb_packet.pr_idx, pending_cnt);
        end
        tick();
    endtask

    task automatic test_squash();
        src_valid = 6'b010111;
        for (int i = 0; i < N_SRC; i++) src_packet[i] = mk(30 + i, 'h300 + i);
        #1;
        tick();
        src_valid = '0;
        #1;
        tick();
        n_checks++;
        if ({cdb_valid, pending_cnt} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL squash_setup: got v=%0b pend=%0d expected 1 3", cdb_valid, pending_cnt);
        end
        squash        = 1'b1;
        src_valid     = 6'b100000;
        src_packet[5] = mk(33, 'h333);
        #1;
        tick();
        squash    = 1'b0;
        src_valid = '0;
        n_checks++;
        if ({cdb_valid, cdb_packet, pending_cnt} !== {1'b0, {PW{1'b0}}, 3'd0}) begin
            n_fail++;
            $display("FAIL squash_clear: got v=%0b pkt=%h pend=%0d expected all zero",
                     cdb_valid, cdb_packet, pending_cnt);
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            tick();
            n_checks++;
            if ({cdb_valid, pending_cnt} !== {1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL squash_quiet[%0d]: got v=%0b pend=%0d expected 0 0", c, cdb_valid, pending_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        src_valid = 6'b000110;
        for (int i = 0; i < N_SRC; i++) src_packet[i] = mk(40 + i, 'h400 + i);
        #1;
        tick();
        src_valid = '0;
        cdb_stall = 1'b1;
        #1;
        tick();
        src_valid = 6'b010000;
        #1;
        tick();
        src_valid = '0;
        n_checks++;
        if ({cdb_valid, pending_cnt} !== {1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL arst_setup: got v=%0b pend=%0d expected 1 2", cdb_valid, pending_cnt);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({cdb_valid, pending_cnt, src_ready} !== {1'b0, 3'd0, 6'h3f}) begin
            n_fail++;
            $display("FAIL arst_immediate: got v=%0b pend=%0d rdy=%b expected 0 0 111111",
                     cdb_valid, pending_cnt, src_ready);
        end
        m_reset();
        #2;
        reset_n   = 1'b1;
        cdb_stall = 1'b0;
        @(posedge clock);
        #1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({cdb_valid, pending_cnt} !== {1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL arst_quiet[%0d]: got v=%0b pend=%0d expected 0 0", c, cdb_valid, pending_cnt);
            end
        end
    endtask

    task automatic test_random();
        bit prev_adv;
        bit prev_sq;
        int idx;
        exp_q.delete();
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                src_valid = 6'($urandom_range(0, 63));
                for (int i = 0; i < N_SRC; i++) begin
                    src_packet[i] = mk(int'($urandom_range(0, 63)), int'(tag));
                    tag++;
                end
                cdb_stall = ($urandom_range(0, 3) == 0);
                squash    = ($urandom_range(0, 29) == 0);
            end else begin
                src_valid = '0;
                cdb_stall = 1'b0;
                squash    = 1'b0;
            end
            #1;
            n_checks++;
            if (src_ready !== m_ready()) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", c, src_ready, m_ready());
            end
            prev_adv = !m_cv || !cdb_stall;
            prev_sq  = squash;
            tick();
            n_checks++;
            if ({cdb_valid, cdb_packet, cdb_src, pending_cnt} !== {m_cv, m_cp, 3'(m_cs), m_pend()}) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got v=%0b pkt=%h src=%0d pend=%0d expected v=%0b pkt=%h src=%0d pend=%0d",
                         c, cdb_valid, cdb_packet, cdb_src, pending_cnt, m_cv, m_cp, m_cs, m_pend());
            end
            if (cdb_valid && prev_adv && !prev_sq) begin
                idx = -1;
                foreach (exp_q[j]) if (idx < 0 && exp_q[j] === cdb_packet) idx = j;
                n_checks++;
                if (idx < 0) begin
                    n_fail++;
                    $display("FAIL rand_sb_unexpected[%0d]: got pkt=%h expected an outstanding accepted packet",
                             c, cdb_packet);
                end else begin
                    exp_q.delete(idx);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_sb_leftover: got %0d undelivered packets expected 0", exp_q.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tag      = 32'h1000;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall_refill();
        test_squash();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/complete_cdb_arb.md
# complete_cdb_arb

Completion-stage arbiter between the functional units and the common data bus (CDB). It accepts completion packets from six FU sources through per-source single-entry holding slots and a valid/ready handshake. Each cycle it selects one held packet and drives it onto a registered CDB output that feeds ROB completion, RS wakeup and PRF valid-bit update. It replaces ad-hoc done-bit merging with explicit backpressure, so an FU never loses a result.

## Interface
- N_SRC, 6: number of FU sources; index 0 ALU_1, 1 ALU_2, 2 ALU_3, 3 MULT_1, 4 MULT_2, 5 BRANCH.
- SRC_W, 3: width of source index, ≥ clog2(N_SRC).
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- src_valid  in  N_SRC  source i presents a completion packet.
- src_packet  in  N_SRC × FU_COMPLETE_PACKET  per-source completion packets.
- src_ready  out  N_SRC  source i's packet is accepted this cycle if src_valid[i].
- cdb_valid  out  1  CDB output holds a valid packet.
- cdb_packet  out  FU_COMPLETE_PACKET  broadcast packet.
- cdb_src  out  SRC_W  source index of cdb_packet.
- cdb_stall  in  1  downstream cannot consume cdb_packet this cycle.
- squash  in  1  pipeline flush; discards all held and in-flight packets.
- pending_cnt  out  SRC_W  number of occupied holding slots.

## Operation
- Per source: one slot (slot_valid[i], slot_pkt[i]). An accept (src_valid[i] & src_ready[i]) writes the slot at the edge.
- Output advance: adv = !cdb_valid | !cdb_stall.
- Arbitration over slot_valid only; incoming packets are not arbitrated in their arrival cycle. grant is one-hot; grant is zero when adv=0 or no slot is occupied.
- src_ready[i] = !slot_valid[i] | grant[i]. This is a combinational path from cdb_stall; a slot drained and refilled in the same edge is legal.
- On grant[w]: cdb_packet ← slot_pkt[w], cdb_src ← w, cdb_valid ← 1, slot_valid[w] ← 0 unless refilled by the same-edge accept.
- adv=1 with no grant: cdb_valid ← 0, cdb_packet ← 0.
- cdb_stall=1 with cdb_valid=1: cdb_valid, cdb_packet and cdb_src hold; all slots hold.
- squash (synchronous, sampled at edge):
  - clears all slot_valid, cdb_valid and cdb_packet.
  - resets the round-robin pointer to 0.
  - drops same-cycle accepts even though src_ready was high.
- pending_cnt = popcount(slot_valid), registered-state derived.

## Timing
- Reset values: cdb_valid 0, cdb_packet 0, cdb_src 0, pending_cnt 0, all slots empty, so src_ready = all ones. Round-robin pointer 0.
- Minimum latency: packet accepted at edge E is granted at edge E+1; cdb_valid is high in cycle E+1..E+2.
- Throughput: one broadcast per cycle while any slot is occupied and cdb_stall=0.
- Worst-case wait with round-robin and no stall: N_SRC−1 grants.
- Assertion of reset_n mid-operation clears everything immediately, regardless of clock.
- Simultaneous squash and cdb_stall: squash wins.

## Configuration
- COMPLETE_CDB_RR_EN defined: round-robin arbitration. The search starts at rr_ptr and wraps modulo N_SRC. After a grant, rr_ptr ← (winner+1) mod N_SRC, so winner 5 wraps rr_ptr to 0.
- Undefined: fixed priority, highest index wins (BRANCH first, then MULT_2 … ALU_1). There is no rr_ptr state.

## Structure
- The shared sys_defs package holds:
  - FU_COMPLETE_PACKET;
  - a CDB_SRC enum (ALU_1=0 … BRANCH=5);
  - `define N_CDB_SRC 6.
- One sub-module, cdb_rr_arb. Inputs: req[N_SRC-1:0], en, clock, reset_n, squash. Output: one-hot grant. It contains rr_ptr under COMPLETE_CDB_RR_EN.

## Test plan
- Reset, then ALU_1 valid with pr_idx=7, dest_value=0x11 for one cycle → src_ready[0]=1; two edges later cdb_valid=1, cdb_src=0, pr_idx=7 for exactly one cycle; pending_cnt returns to 0.
- All six sources valid in the same cycle, no stall, RR enabled → grants in order 0,1,2,3,4,5 on six consecutive cycles. With the macro undefined → order 5,4,3,2,1,0.
- cdb_stall held 3 cycles with cdb_valid=1 → cdb_packet stable, all src_ready=0 for occupied slots; MULT_1 second packet held off until its slot drains.
- Slot 3 granted while MULT_1 presents a new packet in the same cycle → both accepted; the new packet broadcasts on a later grant with no loss or duplication.
- squash in the cycle where three slots are full and cdb_valid=1 → next cycle cdb_valid=0, pending_cnt=0. A packet offered during the squash cycle never appears on the CDB.
- reset_n pulsed low between edges with two slots full → cdb_valid and pending_cnt go to 0 asynchronously; no broadcasts follow.
